switch_debouncer: RTL and testbench

Debounces one raw mechanical switch/button input and produces a clean registered level plus single-cycle rise and fall pulses. It sits directly upstream of the lab's SR flip-flop stage. sw_rise drives S and sw_fall drives R, so the flip-flop never sees bounce, metastability, or S=R=1. The block synchronises the asynchronous input, then qualifies each level change with a stability counter under a four-state FSM.

---
 rtl/switch_debouncer.sv | 153 +++++++++++++++
 tb/tb_switch_debouncer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer
// Cleans up one raw mechanical switch input for the downstream SR flip-flop
// stage. sw_rise drives S and sw_fall drives R. The input is first brought
// into the clk domain by a two-flop synchroniser. A four-state FSM with a
// stability counter then accepts a new level only after it has been seen for
// STABLE_CYCLES consecutive synchronised samples. All outputs come straight
// from flops, so there is no combinational path from sw_raw to any output.
//
// Parameter constraints: STABLE_CYCLES >= 2, and 2**CNT_W > STABLE_CYCLES.

module switch_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall
);

    // FSM encoding. The level states and the wait states are kept distinct,
    // so a candidate that is rejected drops straight back to its idle state.
    localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    // The counter value at which a candidate level is committed. The counter
    // is loaded with 1 on entry to a wait state, so reaching this value means
    // STABLE_CYCLES consecutive agreeing samples have been seen.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Synchroniser chain.
    logic s0_q;
    logic sync_q;

    // FSM and datapath state.
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Two-flop synchroniser: the raw input may be metastable on s0_q. Only
    // sync_q is used by the logic below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            s0_q   <= sw_raw;
            sync_q <= s0_q;
        end
    end

    // Next-state logic. The pulses default low so that each one lasts exactly
    // one cycle. A disagreeing sample in a wait state clears the candidate.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            ST_IDLE_LOW: begin
                if (sync_q) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_WAIT_HIGH: begin
                if (!sync_q) begin
                    state_d = ST_IDLE_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_HIGH;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            ST_IDLE_HIGH: begin
                if (!sync_q) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end

            ST_WAIT_LOW: begin
                if (sync_q) begin
                    state_d = ST_IDLE_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_LOW;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end

            default: begin
                // An illegal encoding cannot be reached from reset. If one
                // appears anyway, recover to the safe low level with no pulse.
                state_d = ST_IDLE_LOW;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers. Reset takes priority and discards
    // any candidate that is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE_LOW;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_level = level_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4 and CNT_W=3.
// Edge numbering: k=1 is the first rising edge that samples a new sw_raw
// value (E0). A committed change is therefore first visible after k=6.
`timescale 1ns/1ps

module tb_switch_debouncer;

    logic clk;
    logic rst_n;
    logic sw_raw;
    logic sw_level;
    logic sw_rise;
    logic sw_fall;

    int vectors     = 0;
    int miscompares = 0;

    logic mon_en     = 1'b0;
    logic rst_prev   = 1'b0;
    logic prev_level = 1'b0;

    switch_debouncer #(
        .STABLE_CYCLES(4),
        .CNT_W        (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .sw_level(sw_level),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember whether the most recent edge was a reset edge.
    always @(posedge clk) rst_prev = rst_n;

    // Invariants that are checked on every falling edge once the bench is running.
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if ((sw_rise & sw_fall) !== 1'b0) begin
                miscompares++;
                $display("FAIL inv_both_pulses rise=%b fall=%b required not both 1", sw_rise, sw_fall);
            end
            vectors++;
            if (dut.cnt_q > 3'd3) begin
                miscompares++;
                $display("FAIL inv_cnt_range cnt=%0d required <=3", dut.cnt_q);
            end
            if (rst_prev === 1'b1) begin
                vectors++;
                if (sw_rise !== (sw_level & ~prev_level) || sw_fall !== (~sw_level & prev_level)) begin
                    miscompares++;
                    $display("FAIL inv_level_pulse prev=%b level=%b rise=%b fall=%b required rise=%b fall=%b",
                             prev_level, sw_level, sw_rise, sw_fall,
                             sw_level & ~prev_level, ~sw_level & prev_level);
                end
            end
            prev_level = sw_level;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold sw_raw at a value long enough for the output to follow it.
    task automatic settle(input logic v);
        sw_raw = v;
        repeat (8) step();
    endtask

    task automatic test_reset();
        logic el;
        logic er;
        rst_n  = 1'b0;
        sw_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            mon_en = 1'b1;
            vectors++;
            if (sw_level !== 1'b0 || sw_rise !== 1'b0 || sw_fall !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold i=%0d level=%b rise=%b fall=%b required 0 0 0",
                         i, sw_level, sw_rise, sw_fall);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            el = (k >= 6);
            er = (k == 6);
            vectors++;
            if (sw_level !== el || sw_rise !== er || sw_fall !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release k=%0d level=%b rise=%b fall=%b required %b %b 0",
                         k, sw_level, sw_rise, sw_fall, el, er);
            end
        end
    endtask

    task automatic test_press_release();
        logic el;
        logic ep;
        settle(1'b0);
        sw_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            el = (k >= 6);
            ep = (k == 6);
            vectors++;
            if (sw_level !== el || sw_rise !== ep || sw_fall !== 1'b0) begin
                miscompares++;
                $display("FAIL press k=%0d level=%b rise=%b fall=%b required %b %b 0",
                         k, sw_level, sw_rise, sw_fall, el, ep);
            end
        end
        sw_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            el = (k < 6);
            ep = (k == 6);
            vectors++;
            if (sw_level !== el || sw_fall !== ep || sw_rise !== 1'b0) begin
                miscompares++;
                $display("FAIL release k=%0d level=%b rise=%b fall=%b required %b 0 %b",
                         k, sw_level, sw_rise, sw_fall, el, ep);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        logic el;
        logic er;
        // The first five bounce values, applied in time order from bit 4 down.
        pat = 5'b10110;
        settle(1'b0);
        for (int i = 4; i >= 0; i--) begin
            sw_raw = pat[i];
            step();
            vectors++;
            if (sw_level !== 1'b0 || sw_rise !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce_phase i=%0d level=%b rise=%b required 0 0", i, sw_level, sw_rise);
            end
        end
        // The final 1 of the bounce is the last 0->1 change, so its edge is k=1.
        sw_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            el = (k >= 6);
            er = (k == 6);
            vectors++;
            if (sw_level !== el || sw_rise !== er || sw_fall !== 1'b0) begin
                miscompares++;
                $display("FAIL bounce_settle k=%0d level=%b rise=%b fall=%b required %b %b 0",
                         k, sw_level, sw_rise, sw_fall, el, er);
            end
        end
    endtask

    task automatic test_glitch();
        logic el;
        logic er;
        logic ef;
        // A high pulse that is 3 cycles wide is too short and must be rejected.
        settle(1'b0);
        for (int k = 1; k <= 12; k++) begin
            sw_raw = (k <= 3);
            step();
            vectors++;
            if (sw_level !== 1'b0 || sw_rise !== 1'b0 || sw_fall !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch3 k=%0d level=%b rise=%b fall=%b required 0 0 0",
                         k, sw_level, sw_rise, sw_fall);
            end
        end
        // A high pulse that is 4 cycles wide is accepted. The reverse change is
        // sampled at k=5, so it commits at k=10.
        for (int k = 1; k <= 14; k++) begin
            sw_raw = (k <= 4);
            step();
            el = (k >= 6 && k <= 9);
            er = (k == 6);
            ef = (k == 10);
            vectors++;
            if (sw_level !== el || sw_rise !== er || sw_fall !== ef) begin
                miscompares++;
                $display("FAIL glitch4 k=%0d level=%b rise=%b fall=%b required %b %b %b",
                         k, sw_level, sw_rise, sw_fall, el, er, ef);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic el;
        logic er;
        settle(1'b0);
        sw_raw = 1'b1;
        // Without the reset, the commit would happen at k=6. The reset is taken at k=4.
        for (int k = 1; k <= 4; k++) begin
            rst_n = (k != 4);
            step();
            vectors++;
            if (sw_level !== 1'b0 || sw_rise !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_pre k=%0d level=%b rise=%b required 0 0", k, sw_level, sw_rise);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            el = (k >= 6);
            er = (k == 6);
            vectors++;
            if (sw_level !== el || sw_rise !== er || sw_fall !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_post k=%0d level=%b rise=%b fall=%b required %b %b 0",
                         k, sw_level, sw_rise, sw_fall, el, er);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sw_raw = 1'b0;
        test_reset();
        test_press_release();
        test_bounce();
        test_glitch();
        test_reset_mid();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
